uart_link_sched: RTL and testbench
==================================

UART_LINK_SCHED -- requirements
Module: uart_link_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000: max cycles in SEND waiting for char_sent.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: idle cycles forced after each character.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_data  in  8  CPU transmit byte.
REQ-006 SHALL have port cpu_load  in  1  one-cycle pulse; captures cpu_data.
REQ-007 SHALL have port cpu_busy  out  1  CPU byte pending or in flight.
REQ-008 SHALL have port game_data  in  8  game-logic transmit byte.
REQ-009 SHALL have port game_req  in  1  level request from game logic.
REQ-010 SHALL have port game_ack  out  1  one-cycle pulse; game_data consumed.
REQ-011 SHALL have port tx_data  out  8  byte to transceiver.
REQ-012 SHALL have port tx_load  out  1  one-cycle parallel-load strobe.
REQ-013 SHALL have port tx_en  out  1  transmit enable (transen).
REQ-014 SHALL have port char_sent  in  1  transceiver finished character.
REQ-015 SHALL have port char_rec  in  1  transceiver received character (level).
REQ-016 SHALL have port rx_data_in  in  8  transceiver receive byte.
REQ-017 SHALL have port rx_data  out  8  held received byte.
REQ-018 SHALL have port rx_valid  out  1  rx_data unread.
REQ-019 SHALL have port rx_ack  in  1  consumer read pulse.
REQ-020 SHALL have port rx_overrun  out  1  sticky: byte dropped.
REQ-021 SHALL have port tx_timeout  out  1  one-cycle pulse: SEND aborted.

Function
REQ-022 SHALL implement TX FSM states IDLE, LOAD, SEND, GAP.
REQ-023 cpu_load while cpu_busy=0 SHALL register cpu_data into a pending buffer and set cpu_busy next cycle; cpu_load while cpu_busy=1 SHALL be ignored.
REQ-024 IDLE SHALL grant when CPU pending or game_req=1; on tie, grant the requester that did not own the previous transfer; last-owner resets to game (CPU wins first tie).
REQ-025 On grant, tx_data SHALL latch the owner's byte and the FSM SHALL enter LOAD; game_ack SHALL pulse in that LOAD cycle when owner is game.
REQ-026 LOAD SHALL last exactly one cycle with tx_load=1; with FSM idle, tx_load SHALL assert exactly 2 cycles after a cpu_load pulse.
REQ-027 SEND SHALL hold tx_en=1 and exit to GAP on the first cycle char_sent=1.
REQ-028 GAP SHALL hold tx_en=0 for GAP_CYCLES cycles, then IDLE; cpu_busy SHALL clear on GAP entry when owner is CPU.
REQ-029 tx_data SHALL remain stable from LOAD until IDLE.
REQ-030 RX: char_rec SHALL be edge-detected with one register; each rising edge captures rx_data_in into rx_data and sets rx_valid.
REQ-031 rx_ack SHALL clear rx_valid next cycle; rx_ack with rx_valid=0 SHALL have no effect.
REQ-032 A capture edge while rx_valid=1 without rx_ack SHALL drop the new byte, keep rx_data, and set rx_overrun until reset.
REQ-033 A capture edge coinciding with rx_ack SHALL store the new byte, keep rx_valid=1, and not flag overrun.
REQ-034 RX and TX paths SHALL operate concurrently and independently.

Reset
REQ-035 Reset SHALL force IDLE, clear pending buffer, edge register, gap/timeout counters; tx_data=0, rx_data=0, all outputs 0.
REQ-036 Reset asserted mid-SEND SHALL drop tx_en in the next cycle; the in-flight byte is discarded without game_ack re-issue.

Configuration
REQ-037 With LINK_SCHED_TIMEOUT_EN defined, a TIMEOUT-cycle counter SHALL run in SEND; on expiry, FSM SHALL go to GAP and pulse tx_timeout; owner cleared as if sent.
REQ-038 Without LINK_SCHED_TIMEOUT_EN, SEND SHALL wait indefinitely, tx_timeout SHALL be tied 0, no counter SHALL be synthesized.

Verification
REQ-039 Idle, cpu_load with cpu_data=0x41 -> tx_load high 2 cycles later, tx_data=0x41, tx_en until char_sent, cpu_busy clears at GAP entry.
REQ-040 cpu pending and game_req with game_data=0x7E at reset -> CPU 0x41 sent first, then 0x7E with single game_ack pulse in its LOAD cycle.
REQ-041 Two char_rec edges (0x10, 0x20) without rx_ack -> rx_data=0x10, rx_overrun=1; repeat with rx_ack on second edge -> rx_data=0x20, rx_overrun=0.
REQ-042 Timeout enabled, TIMEOUT=16, char_sent held 0 -> tx_timeout pulse after 16 SEND cycles, GAP of 4, IDLE.
REQ-043 Reset asserted during SEND -> tx_en=0 next cycle, cpu_busy=0, rx_valid=0, FSM accepts new cpu_load afterwards.

Source files
------------

// File: rtl/uart_link_sched.sv
// ============================================================================
// Module  : uart_link_sched
// Brief   : Arbitrates CPU and game-logic bytes onto one UART transceiver and
//           buffers received bytes. Optional SEND watchdog: LINK_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_link_sched #(
   parameter int TIMEOUT    = 50000,
   parameter int GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cpu_data,
   input  logic       cpu_load,
   output logic       cpu_busy,
   input  logic [7:0] game_data,
   input  logic       game_req,
   output logic       game_ack,
   output logic [7:0] tx_data,
   output logic       tx_load,
   output logic       tx_en,
   input  logic       char_sent,
   input  logic       char_rec,
   input  logic [7:0] rx_data_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       tx_timeout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

   state_t             r_state;
   logic [7:0]         r_cpu_buf;
   logic               r_cpu_pend;
   logic               r_cpu_busy;
   logic               r_owner_cpu;
   logic               r_last_cpu;
   logic [c_gap_w-1:0] r_gap_cnt;
   logic [7:0]         r_tx_data;
   logic               r_tx_load;
   logic               r_tx_en;
   logic               r_game_ack;
   logic               w_grant_cpu;

`ifdef LINK_SCHED_TIMEOUT_EN
   localparam int c_to_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);
   logic [c_to_w-1:0] r_to_cnt;
   logic              r_tx_timeout;
   assign tx_timeout = r_tx_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);
   assign tx_timeout       = 1'b0;
`endif

   // CPU wins unless the game is also asking and the CPU owned the last transfer.
   assign w_grant_cpu = r_cpu_pend && (!game_req || !r_last_cpu);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cpu_buf   <= 8'h00;
         r_cpu_pend  <= 1'b0;
         r_cpu_busy  <= 1'b0;
         r_owner_cpu <= 1'b0;
         r_last_cpu  <= 1'b0;
         r_gap_cnt   <= '0;
         r_tx_data   <= 8'h00;
         r_tx_load   <= 1'b0;
         r_tx_en     <= 1'b0;
         r_game_ack  <= 1'b0;
`ifdef LINK_SCHED_TIMEOUT_EN
         r_to_cnt     <= '0;
         r_tx_timeout <= 1'b0;
`endif
      end else begin
         r_tx_load  <= 1'b0;
         r_game_ack <= 1'b0;
`ifdef LINK_SCHED_TIMEOUT_EN
         r_tx_timeout <= 1'b0;
`endif
         if (cpu_load && !r_cpu_busy) begin
            r_cpu_buf  <= cpu_data;
            r_cpu_pend <= 1'b1;
            r_cpu_busy <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (r_cpu_pend || game_req) begin
                  r_owner_cpu <= w_grant_cpu;
                  r_last_cpu  <= w_grant_cpu;
                  r_tx_data   <= w_grant_cpu ? r_cpu_buf : game_data;
                  r_tx_load   <= 1'b1;
                  if (w_grant_cpu) r_cpu_pend <= 1'b0;
                  else             r_game_ack <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_tx_en <= 1'b1;
`ifdef LINK_SCHED_TIMEOUT_EN
               r_to_cnt <= '0;
`endif
               r_state <= S_SEND;
            end
            S_SEND: begin
               if (char_sent) begin
                  r_tx_en   <= 1'b0;
                  r_gap_cnt <= '0;
                  if (r_owner_cpu) r_cpu_busy <= 1'b0;
                  r_state <= S_GAP;
               end
`ifdef LINK_SCHED_TIMEOUT_EN
               else if (r_to_cnt == c_to_last) begin
                  r_tx_en      <= 1'b0;
                  r_gap_cnt    <= '0;
                  r_tx_timeout <= 1'b1;
                  if (r_owner_cpu) r_cpu_busy <= 1'b0;
                  r_state <= S_GAP;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            S_GAP: begin
               if (r_gap_cnt == c_gap_last) r_state <= S_IDLE;
               else                         r_gap_cnt <= r_gap_cnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cpu_busy = r_cpu_busy;
   assign game_ack = r_game_ack;
   assign tx_data  = r_tx_data;
   assign tx_load  = r_tx_load;
   assign tx_en    = r_tx_en;

   logic       r_rec_d;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_rx_overrun;
   logic       w_rec_rise;

   assign w_rec_rise = char_rec && !r_rec_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rec_d      <= 1'b0;
         r_rx_data    <= 8'h00;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         r_rec_d <= char_rec;
         // A read in the same cycle frees the holding register for the new byte.
         if (w_rec_rise && (!r_rx_valid || rx_ack)) begin
            r_rx_data  <= rx_data_in;
            r_rx_valid <= 1'b1;
         end else if (w_rec_rise) begin
            r_rx_overrun <= 1'b1;
         end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign rx_overrun = r_rx_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_link_sched.sv
// ============================================================================
// Module  : tb_uart_link_sched
// Brief   : Directed self-checking bench for uart_link_sched (RX vector table
//           plus hand-written TX sequences).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_link_sched;

   localparam int c_timeout = 16;
   localparam int c_gap     = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] cpu_data;
   logic       cpu_load;
   logic       cpu_busy;
   logic [7:0] game_data;
   logic       game_req;
   logic       game_ack;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_en;
   logic       char_sent;
   logic       char_rec;
   logic [7:0] rx_data_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       rx_overrun;
   logic       tx_timeout;

   uart_link_sched #(.TIMEOUT(c_timeout), .GAP_CYCLES(c_gap)) dut (
      .clk(clk), .reset(reset),
      .cpu_data(cpu_data), .cpu_load(cpu_load), .cpu_busy(cpu_busy),
      .game_data(game_data), .game_req(game_req), .game_ack(game_ack),
      .tx_data(tx_data), .tx_load(tx_load), .tx_en(tx_en),
      .char_sent(char_sent), .char_rec(char_rec), .rx_data_in(rx_data_in),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
      .rx_overrun(rx_overrun), .tx_timeout(tx_timeout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_load(input string name, input int budget);
      int n = 0;
      while (tx_load !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(name, {31'd0, tx_load}, 32'd1);
   endtask

   typedef struct {
      logic       rst;
      logic       cr;
      logic [7:0] din;
      logic       ack;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_ovr;
   } rx_vec_t;

   rx_vec_t rx_tab[12];

   initial begin
      int seen_load;
      int seen_ack;
      int bad_en;

      rx_tab[0]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0};
      rx_tab[1]  = '{1'b0, 1'b0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
      rx_tab[2]  = '{1'b0, 1'b1, 8'h20, 1'b0, 8'h10, 1'b1, 1'b1};
      rx_tab[3]  = '{1'b0, 1'b0, 8'h20, 1'b1, 8'h10, 1'b0, 1'b1};
      rx_tab[4]  = '{1'b0, 1'b0, 8'h20, 1'b1, 8'h10, 1'b0, 1'b1};
      rx_tab[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      rx_tab[6]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0};
      rx_tab[7]  = '{1'b0, 1'b0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
      rx_tab[8]  = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h20, 1'b1, 1'b0};
      rx_tab[9]  = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0, 1'b0};
      rx_tab[10] = '{1'b0, 1'b0, 8'h33, 1'b0, 8'h20, 1'b0, 1'b0};
      rx_tab[11] = '{1'b0, 1'b1, 8'h33, 1'b0, 8'h33, 1'b1, 1'b0};

      reset = 1'b1; cpu_data = 8'h00; cpu_load = 1'b0; game_data = 8'h00;
      game_req = 1'b0; char_sent = 1'b0; char_rec = 1'b0; rx_data_in = 8'h00;
      rx_ack = 1'b0;
      step(); step();
      check("rst_tx_data",  {24'd0, tx_data}, 32'h0);
      check("rst_tx_load",  {31'd0, tx_load}, 32'h0);
      check("rst_tx_en",    {31'd0, tx_en}, 32'h0);
      check("rst_cpu_busy", {31'd0, cpu_busy}, 32'h0);
      check("rst_game_ack", {31'd0, game_ack}, 32'h0);
      check("rst_rx_data",  {24'd0, rx_data}, 32'h0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'h0);
      check("rst_rx_ovr",   {31'd0, rx_overrun}, 32'h0);
      check("rst_timeout",  {31'd0, tx_timeout}, 32'h0);
      reset = 1'b0;

      // RX path, one row per clock
      for (int i = 0; i < 12; i++) begin
         reset = rx_tab[i].rst; char_rec = rx_tab[i].cr;
         rx_data_in = rx_tab[i].din; rx_ack = rx_tab[i].ack;
         step();
         check($sformatf("rx%0d_data", i),  {24'd0, rx_data}, {24'd0, rx_tab[i].exp_data});
         check($sformatf("rx%0d_valid", i), {31'd0, rx_valid}, {31'd0, rx_tab[i].exp_valid});
         check($sformatf("rx%0d_ovr", i),   {31'd0, rx_overrun}, {31'd0, rx_tab[i].exp_ovr});
      end
      reset = 1'b0; char_rec = 1'b0; rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;

      // Tie after reset: CPU first, then game with one ack; also measures the gap
      cpu_data = 8'h41; cpu_load = 1'b1;
      step();
      check("b_busy_set", {31'd0, cpu_busy}, 32'd1);
      check("b_no_early_load", {31'd0, tx_load}, 32'd0);
      cpu_load = 1'b0; game_req = 1'b1; game_data = 8'h7E;
      step();
      check("b_cpu_load", {31'd0, tx_load}, 32'd1);
      check("b_cpu_data", {24'd0, tx_data}, 32'h41);
      check("b_no_ack_cpu", {31'd0, game_ack}, 32'd0);
      step();
      check("b_tx_en", {31'd0, tx_en}, 32'd1);
      char_sent = 1'b1;
      step();
      char_sent = 1'b0;
      check("b_gap_en", {31'd0, tx_en}, 32'd0);
      check("b_busy_clr", {31'd0, cpu_busy}, 32'd0);
      seen_load = 0; seen_ack = 0;
      for (int i = 0; i < c_gap; i++) begin
         step();
         seen_load += int'(tx_load);
         seen_ack  += int'(game_ack);
      end
      check("b_gap_quiet", seen_load + seen_ack, 32'd0);
      check("b_gap_data_hold", {24'd0, tx_data}, 32'h41);
      step();
      check("b_game_load", {31'd0, tx_load}, 32'd1);
      check("b_game_data", {24'd0, tx_data}, 32'h7E);
      check("b_game_ack", {31'd0, game_ack}, 32'd1);
      game_req = 1'b0;
      step();
      check("b_ack_pulse", {31'd0, game_ack}, 32'd0);
      check("b_game_en", {31'd0, tx_en}, 32'd1);
      char_sent = 1'b1;
      step();
      char_sent = 1'b0;
      seen_load = 0; seen_ack = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen_load += int'(tx_load);
         seen_ack  += int'(game_ack);
      end
      check("b_no_reissue", seen_load + seen_ack, 32'd0);

      // Single CPU byte; a load while busy must be ignored
      cpu_data = 8'h41; cpu_load = 1'b1;
      step();
      cpu_load = 1'b0;
      step();
      check("a_load", {31'd0, tx_load}, 32'd1);
      check("a_data", {24'd0, tx_data}, 32'h41);
      step();
      check("a_en", {31'd0, tx_en}, 32'd1);
      cpu_data = 8'h55; cpu_load = 1'b1;
      step();
      cpu_load = 1'b0;
      bad_en = 0;
`ifdef LINK_SCHED_TIMEOUT_EN
      for (int i = 0; i < c_timeout - 2; i++) begin
         step();
         if (tx_en !== 1'b1 || tx_timeout !== 1'b0) bad_en++;
      end
      check("a_send_held", bad_en, 32'd0);
      step();
      check("a_timeout_pulse", {31'd0, tx_timeout}, 32'd1);
      check("a_timeout_en", {31'd0, tx_en}, 32'd0);
      check("a_timeout_busy", {31'd0, cpu_busy}, 32'd0);
      step();
      check("a_timeout_once", {31'd0, tx_timeout}, 32'd0);
`else
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx_en !== 1'b1 || tx_timeout !== 1'b0) bad_en++;
      end
      check("a_send_wait", bad_en, 32'd0);
      check("a_busy_in_send", {31'd0, cpu_busy}, 32'd1);
      char_sent = 1'b1;
      step();
      char_sent = 1'b0;
      check("a_gap_en", {31'd0, tx_en}, 32'd0);
      check("a_busy_clr", {31'd0, cpu_busy}, 32'd0);
      check("a_data_hold", {24'd0, tx_data}, 32'h41);
`endif
      seen_load = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen_load += int'(tx_load);
      end
      check("a_ignored_load", seen_load, 32'd0);

      // Reset in the middle of SEND, then recovery
      cpu_data = 8'h3C; cpu_load = 1'b1;
      step();
      cpu_load = 1'b0;
      step(); step();
      char_rec = 1'b1; rx_data_in = 8'h77;
      step();
      check("c_in_send", {31'd0, tx_en}, 32'd1);
      check("c_rx_valid", {31'd0, rx_valid}, 32'd1);
      reset = 1'b1; char_rec = 1'b0;
      step();
      reset = 1'b0;
      check("c_rst_en", {31'd0, tx_en}, 32'd0);
      check("c_rst_busy", {31'd0, cpu_busy}, 32'd0);
      check("c_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("c_rst_data", {24'd0, tx_data}, 32'h0);
      cpu_data = 8'h5A; cpu_load = 1'b1;
      step();
      cpu_load = 1'b0;
      check("c_busy_again", {31'd0, cpu_busy}, 32'd1);
      step();
      check("c_load_after_rst", {31'd0, tx_load}, 32'd1);
      check("c_data_after_rst", {24'd0, tx_data}, 32'h5A);
      step();

      // CPU owned the last transfer, so a tie now goes to the game
      game_req = 1'b1; game_data = 8'h99;
      char_sent = 1'b1;
      step();
      char_sent = 1'b0;
      cpu_data = 8'h66; cpu_load = 1'b1;
      step();
      cpu_load = 1'b0;
      wait_load("d_tie_load", 10);
      check("d_tie_game", {24'd0, tx_data}, 32'h99);
      check("d_tie_ack", {31'd0, game_ack}, 32'd1);
      game_req = 1'b0;
      step(); step();
      char_sent = 1'b1;
      step();
      char_sent = 1'b0;
      wait_load("d_cpu_load", 10);
      check("d_cpu_data", {24'd0, tx_data}, 32'h66);
      check("d_cpu_no_ack", {31'd0, game_ack}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
